// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART debug bus master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_BUS       = 3'd3,
    ST_SEND      = 3'd4,
    ST_SEND_WAIT = 3'd5
  } state_t;

  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

  // True for the two command bytes the bridge understands.
  function automatic logic is_cmd(input logic [7:0] c);
    return (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

endpackage

// File: rtl/uart_dbg_txbuf.sv
// Response shift buffer: holds up to 4 bytes and presents them LSB first.
// Latency: tx_valid is combinational from the SEND phase of the command FSM.
// Backpressure: the next byte only advances on tx_ready while in the wait phase.
module uart_dbg_txbuf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_dat,
  input  logic [1:0]  load_cnt,
  input  logic        send,
  input  logic        wait_st,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last
);

  logic [31:0] shreg_q;
  logic [1:0]  cnt_q;

  // Load a fresh response, or drop the sent byte once the transmitter is done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg_q <= 32'h0;
      cnt_q   <= 2'd0;
    end else if (load) begin
      shreg_q <= load_dat;
      cnt_q   <= load_cnt;
    end else if (wait_st && tx_ready) begin
      shreg_q <= {8'h00, shreg_q[31:8]};
      if (cnt_q != 2'd0) begin
        cnt_q <= cnt_q - 2'd1;
      end
    end
  end

  // Byte is only driven while it is being launched, so the bus idles at zero.
  always_comb begin
    tx_valid = send;
    tx_data  = send ? shreg_q[7:0] : 8'h00;
    last     = (cnt_q == 2'd0);
  end

endmodule

// File: rtl/uart_dbg_master.sv
// Debug bridge: decodes 'R'/'W' byte commands and issues single-word bus transactions; optional bus timeout under UART_DBG_TIMEOUT_EN.
// Latency: mem_valid 1 cycle after the last command byte; first tx_valid 1 cycle after mem_ready.
// Backpressure: bytes arriving while busy on the bus or transmitting are dropped and flagged on rx_overrun.
module uart_dbg_master
  import uart_dbg_pkg::*;
#(
`ifdef UART_DBG_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 4096,
`endif
  parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        rx_overrun
);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  byte_cnt_q;
  logic        timeout;
  logic        tx_last;
  logic        ld_en;
  logic [31:0] ld_dat;
  logic [1:0]  ld_cnt;
  logic        is_bus;
  logic        is_wr;

`ifdef UART_DBG_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  // Cycles spent in the current bus access; zero on the first BUS cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt_q <= 32'h0;
    end else if (state_q != ST_BUS) begin
      to_cnt_q <= 32'h0;
    end else begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  // Last permitted bus cycle; mem_ready in this same cycle still wins.
  assign timeout = (state_q == ST_BUS) && (to_cnt_q == TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command, address and data capture; byte counter restarts on every state change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q      <= 8'h00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      byte_cnt_q <= 2'd0;
    end else begin
      if (state_q == ST_IDLE && rx_valid) begin
        cmd_q <= rx_data;
      end
      if (state_q == ST_GET_ADDR && rx_valid) begin
        addr_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
      end
      if (state_q == ST_GET_DATA && rx_valid) begin
        wdata_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
      end
      if (state_d != state_q) begin
        byte_cnt_q <= 2'd0;
      end else if ((state_q == ST_GET_ADDR || state_q == ST_GET_DATA) && rx_valid) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          state_d = is_cmd(rx_data) ? ST_GET_ADDR : ST_SEND;
        end
      end
      ST_GET_ADDR: begin
        if (rx_valid && byte_cnt_q == 2'd3) begin
          if (addr_q[1:0] != 2'b00) begin
            state_d = ST_SEND;
          end else if (cmd_q == CMD_WRITE) begin
            state_d = ST_GET_DATA;
          end else begin
            state_d = ST_BUS;
          end
        end
      end
      ST_GET_DATA: begin
        if (rx_valid && byte_cnt_q == 2'd3) begin
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (mem_ready || timeout) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_SEND_WAIT;
      end
      ST_SEND_WAIT: begin
        if (tx_ready) begin
          state_d = tx_last ? ST_IDLE : ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs and response loading; the low address byte is already held when the 4th byte lands.
  always_comb begin
    is_bus     = (state_q == ST_BUS);
    is_wr      = (cmd_q == CMD_WRITE);
    busy       = (state_q != ST_IDLE);
    mem_valid  = is_bus;
    mem_addr   = is_bus ? addr_q : 32'h0;
    mem_wdata  = (is_bus && is_wr) ? wdata_q : 32'h0;
    mem_wstrb  = (is_bus && is_wr) ? 4'hF : 4'h0;
    rx_overrun = rx_valid && (state_q == ST_BUS || state_q == ST_SEND ||
                              state_q == ST_SEND_WAIT);
    ld_en  = 1'b0;
    ld_dat = {24'h0, NAK_BYTE};
    ld_cnt = 2'd0;
    case (state_q)
      ST_IDLE: begin
        ld_en = rx_valid && !is_cmd(rx_data);
      end
      ST_GET_ADDR: begin
        ld_en = rx_valid && (byte_cnt_q == 2'd3) && (addr_q[1:0] != 2'b00);
      end
      ST_BUS: begin
        if (mem_ready) begin
          ld_en = 1'b1;
          if (is_wr) begin
            ld_dat = {24'h0, ACK_BYTE};
          end else begin
            ld_dat = mem_rdata;
            ld_cnt = 2'd3;
          end
        end else if (timeout) begin
          ld_en = 1'b1;
        end
      end
      default: begin
        ld_en = 1'b0;
      end
    endcase
  end

  uart_dbg_txbuf u_txbuf (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ld_en),
    .load_dat (ld_dat),
    .load_cnt (ld_cnt),
    .send     (state_q == ST_SEND),
    .wait_st  (state_q == ST_SEND_WAIT),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .last     (tx_last)
  );

endmodule

// File: tb/tb_uart_dbg_master.sv
// Directed bench for uart_dbg_master with a queue-based response/bus model.
// Latency: checks command-to-bus and bus-to-first-byte cycle counts.
// Backpressure: bench transmitter returns tx_ready 3 cycles after each tx_valid.
module tb_uart_dbg_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic        rx_overrun;

`ifdef UART_DBG_TIMEOUT_EN
  localparam int TO_LEN = 16;
`else
  localparam int TO_LEN = 0;
`endif

  uart_dbg_master #(
`ifdef UART_DBG_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .ACK_BYTE(8'h06),
    .NAK_BYTE(8'h15)
  ) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  bit          resp_en = 1'b1;
  int          resp_wait = 0;
  logic [31:0] resp_rdata = 32'h0;
  bit          first_tx_pending = 1'b0;
  bit          first_from_bus = 1'b0;
  bit          ovr_expect = 1'b0;

  // What the bridge must do for one host command, from the protocol rules.
  task automatic predict(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    bus_t t;
    first_tx_pending = 1'b1;
    if ((c != 8'h52 && c != 8'h57) || (a % 4 != 0)) begin
      first_from_bus = 1'b0;
      exp_tx.push_back(8'h15);
      return;
    end
    first_from_bus = 1'b1;
    t.addr  = a;
    t.wdata = (c == 8'h57) ? d : 32'h0;
    t.wstrb = (c == 8'h57) ? 4'hF : 4'h0;
    if (resp_en) begin
      t.len = resp_wait + 1;
      if (c == 8'h52) begin
        for (int i = 0; i < 4; i++) exp_tx.push_back(resp_rdata[8*i +: 8]);
      end else begin
        exp_tx.push_back(8'h06);
      end
    end else begin
      t.len = TO_LEN;
      exp_tx.push_back(8'h15);
    end
    exp_bus.push_back(t);
  endtask

  // ---------------- environment ----------------
  // Bus responder: ready after resp_wait wait cycles.
  initial begin : responder
    int wcnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (mem_valid && resp_en) begin
        if (wcnt == resp_wait) begin
          mem_ready = 1'b1;
          mem_rdata = resp_rdata;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (!mem_valid) begin
        wcnt = 0;
      end
    end
  end

  // Transmitter: tx_ready pulse 3 cycles after each tx_valid.
  initial begin : transmitter
    bit txb = 1'b0;
    int txl = 0;
    forever begin
      @(posedge clk); #1;
      tx_ready = 1'b0;
      if (!resetn) txb = 1'b0;
      if (txb) begin
        if (txl == 0) begin
          tx_ready = 1'b1;
          txb = 1'b0;
        end else begin
          txl--;
        end
      end
      if (tx_valid) begin
        txb = 1'b1;
        txl = 2;
      end
    end
  end

  // ---------------- compare process ----------------
  int          cyc = 0;
  int          last_rx_cyc = 0;
  int          last_bus_cyc = 0;
  int          mv_len = 0;
  int          last_mv_len = 0;
  int          bus_rises = 0;
  int          tx_seen = 0;
  bit          prev_mv = 1'b0;
  bit          tx_out = 1'b0;
  bus_t        cur;
  logic [31:0] obs_addr = 32'h0;
  logic [31:0] obs_wdata = 32'h0;
  logic [3:0]  obs_wstrb = 4'h0;
  logic [7:0]  last_tx = 8'h00;
  logic [31:0] last4 = 32'h0;

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        prev_mv = 1'b0;
        tx_out = 1'b0;
        first_tx_pending = 1'b0;
        continue;
      end
      if (rx_valid) last_rx_cyc = cyc;
      chk("rx_overrun", rx_overrun, ovr_expect);
      if (mem_valid || tx_valid) chk("busy_active", busy, 1);
      if (mem_valid && !prev_mv) begin
        bus_rises++;
        chk("bus_expected", exp_bus.size() > 0, 1);
        if (exp_bus.size() > 0) cur = exp_bus.pop_front();
        else begin cur.addr = 'x; cur.wdata = 'x; cur.wstrb = 'x; cur.len = -1; end
        chk("bus_latency", cyc, last_rx_cyc + 1);
        mv_len = 0;
      end
      if (mem_valid) begin
        mv_len++;
        last_bus_cyc = cyc;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_wstrb", mem_wstrb, cur.wstrb);
      end
      if (!mem_valid && prev_mv) begin
        chk("bus_len", mv_len, cur.len);
        last_mv_len = mv_len;
      end
      prev_mv = mem_valid;
      if (tx_valid) begin
        chk("tx_after_ready", tx_out, 0);
        if (first_tx_pending) begin
          chk("tx_latency", cyc, (first_from_bus ? last_bus_cyc : last_rx_cyc) + 1);
          first_tx_pending = 1'b0;
        end
        chk("tx_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) chk("tx_data", tx_data, exp_tx.pop_front());
        last_tx = tx_data;
        last4 = {tx_data, last4[31:8]};
        tx_seen++;
        tx_out = 1'b1;
      end
      if (tx_ready) tx_out = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d, input int n);
    predict(c, a, d);
    send_byte(c);
    if (n >= 5) for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (n >= 9) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_tx_drained"}, exp_tx.size(), 0);
    chk({tag, "_bus_drained"}, exp_bus.size(), 0);
  endtask

  // Drop a byte in after the first tx_valid of the current response.
  task automatic inject_rx(input logic [7:0] b, input int delay, input bit want_ready);
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("inject_saw_tx", tx_valid, 1);
    repeat (delay) @(posedge clk);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    ovr_expect = 1'b1;
    @(negedge clk);
    chk("overrun_pulse", rx_overrun, 1);
    if (want_ready) chk("overlap_tx_ready", tx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    ovr_expect = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int rises0;
    int tx0;
    repeat (2) @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Write
    resp_wait = 1;
    run_cmd(8'h57, 32'h2000_0000, 32'hDEAD_BEEF, 9);
    wait_idle("write");
    chk("write_addr_lit", obs_addr, 32'h2000_0000);
    chk("write_wdata_lit", obs_wdata, 32'hDEAD_BEEF);
    chk("write_wstrb_lit", obs_wstrb, 4'hF);
    chk("write_ack_lit", last_tx, 8'h06);
    chk("write_len_lit", last_mv_len, 2);

    // Read with 3 wait cycles
    resp_wait = 3;
    resp_rdata = 32'h1234_5678;
    tx0 = tx_seen;
    run_cmd(8'h52, 32'h0000_0004, 32'h0, 5);
    wait_idle("read");
    chk("read_len_lit", last_mv_len, 4);
    chk("read_bytes_lit", last4, 32'h1234_5678);
    chk("read_count_lit", tx_seen - tx0, 4);
    chk("read_wstrb_lit", obs_wstrb, 4'h0);

    // Misaligned read and write: no bus access
    rises0 = bus_rises;
    run_cmd(8'h52, 32'h0000_0002, 32'h0, 5);
    wait_idle("misalign_rd");
    chk("misalign_rd_nak_lit", last_tx, 8'h15);
    run_cmd(8'h57, 32'h0000_0103, 32'h0, 5);
    wait_idle("misalign_wr");
    chk("misalign_no_bus", bus_rises - rises0, 0);

    // Bad command, then a normal read
    run_cmd(8'h41, 32'h0, 32'h0, 1);
    wait_idle("badcmd");
    chk("badcmd_nak_lit", last_tx, 8'h15);
    resp_wait = 0;
    resp_rdata = 32'hA5A5_0F0F;
    run_cmd(8'h52, 32'h0000_0100, 32'h0, 5);
    wait_idle("after_bad");
    chk("after_bad_bytes_lit", last4, 32'hA5A5_0F0F);

    // Overrun during SEND_WAIT leaves the response intact
    resp_wait = 2;
    resp_rdata = 32'hCAFE_F00D;
    run_cmd(8'h52, 32'h0000_0008, 32'h0, 5);
    inject_rx(8'h99, 1, 1'b0);
    wait_idle("overrun");
    chk("overrun_bytes_lit", last4, 32'hCAFE_F00D);

    // rx byte coinciding with the final tx_ready is still dropped
    run_cmd(8'h41, 32'h0, 32'h0, 1);
    inject_rx(8'h52, 3, 1'b1);
    wait_idle("overlap");

`ifdef UART_DBG_TIMEOUT_EN
    // Responder never ready: abort after 16 bus cycles
    resp_en = 1'b0;
    run_cmd(8'h52, 32'h0000_0040, 32'h0, 5);
    wait_idle("timeout");
    chk("timeout_len_lit", last_mv_len, 16);
    chk("timeout_nak_lit", last_tx, 8'h15);
    resp_en = 1'b1;
`else
    // Long bus stall still completes
    resp_wait = 40;
    resp_rdata = 32'h0102_0304;
    run_cmd(8'h52, 32'h0000_0040, 32'h0, 5);
    wait_idle("long_wait");
    chk("long_len_lit", last_mv_len, 41);
    chk("long_bytes_lit", last4, 32'h0102_0304);
`endif

    // Reset in the middle of a bus access
    resp_en = 1'b0;
    tx0 = tx_seen;
    run_cmd(8'h52, 32'h0000_0010, 32'h0, 5);
    repeat (3) @(posedge clk);
    chk("pre_reset_mem_valid", mem_valid, 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("reset_mem_valid_async", mem_valid, 0);
    chk("reset_busy_async", busy, 0);
    chk("reset_mem_addr_async", mem_addr, 0);
    exp_tx.delete();
    exp_bus.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    resp_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("reset_no_tx", tx_seen - tx0, 0);
    chk("reset_idle", busy, 0);

    // Bridge is usable again after reset
    resp_wait = 2;
    run_cmd(8'h57, 32'h0000_0010, 32'h0BAD_F00D, 9);
    wait_idle("post_reset");
    chk("post_reset_ack_lit", last_tx, 8'h06);
    chk("post_reset_len_lit", last_mv_len, 3);
    chk("post_reset_wdata_lit", obs_wdata, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_dbg_master.md
Name: uart_dbg_master

Overview:
- Byte-stream debug bridge: decodes host commands arriving from the rx_uart byte stream and issues single-word transactions as an initiator on the SoC valid/ready memory bus.
- Responses go back through the tx_uart byte interface.
- Sits beside the CPU; an external arbiter muxes its bus port with the CPU's.
- Used for flash-less program load and peek/poke of BRAM, SDRAM and IO.

Parameters:
- TIMEOUT_CYCLES, 4096, bus cycles to wait for mem_ready before aborting (timeout build only).
- ACK_BYTE, 8'h06, response byte for a completed write.
- NAK_BYTE, 8'h15, response byte for an error.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  one-cycle strobe, start transmission
- tx_ready  in  1  one-cycle pulse, transmitter finished the last byte
- mem_valid  out  1  bus request
- mem_addr  out  32  byte address, word aligned
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b1111 for write, 4'b0000 for read
- mem_ready  in  1  bus completion
- mem_rdata  in  32  read data, valid with mem_ready
- busy  out  1  high whenever state != IDLE
- rx_overrun  out  1  one-cycle pulse, rx byte dropped

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0: tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, rx_overrun. Counters cleared. Reset mid-transaction drops mem_valid immediately; no response is sent.
- Command protocol. All multi-byte fields are little-endian.
  - 'R' (8'h52) + addr[4 bytes] → read; reply 4 data bytes, LSB first.
  - 'W' (8'h57) + addr[4 bytes] + data[4 bytes] → write; reply ACK_BYTE.
  - Any other command byte → reply NAK_BYTE, back to IDLE.
- States: IDLE, GET_ADDR, GET_DATA, BUS, SEND, SEND_WAIT.
  - IDLE: on rx_valid, latch cmd. Valid cmd → GET_ADDR with byte_cnt=0. Invalid cmd → SEND with NAK.
  - GET_ADDR: on each rx_valid, shift into addr[8*byte_cnt +: 8]. After the 4th byte:
    - addr[1:0]!=0 → SEND NAK, no bus access.
    - 'W' → GET_DATA.
    - 'R' → BUS.
  - GET_DATA: 4 bytes into wdata, then BUS.
  - BUS: mem_valid=1 with addr, wdata and strobe held stable until the cycle mem_ready is sampled high. mem_valid is 0 the next cycle.
    - Read: capture mem_rdata, load 4-byte tx buffer, tx_cnt=3.
    - Write: load ACK into tx buffer.
  - SEND: tx_valid=1 for exactly one cycle with tx_data = buffer[7:0] → SEND_WAIT.
  - SEND_WAIT: on tx_ready, shift the buffer right by 8. If tx_cnt==0 → IDLE, else decrement and → SEND.
- Latency: mem_valid rises 1 cycle after the final command byte strobe. First tx_valid rises 1 cycle after the mem_ready cycle.
- rx_valid in BUS, SEND or SEND_WAIT: byte discarded, rx_overrun pulses one cycle.
- rx_valid and tx_ready in the same cycle: each is handled by its own rule.
- No inter-byte timeout. A partial command waits indefinitely; the host resyncs by resetting.
- byte_cnt is 2 bits and wraps to 0 on each state exit.

Optional Feature:
- Macro: UART_DBG_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to BUS and increments every BUS cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ready: drop mem_valid, send NAK_BYTE, go to IDLE.
  - mem_ready in the same cycle as the timeout counts as success.
- Undefined: no counter; BUS waits forever.

Decomposition:
- Shared package (uart_dbg_pkg):
  - State enum encoding.
  - CMD_READ=8'h52 and CMD_WRITE=8'h57.
  - Default ACK and NAK values.
- One natural sub-module: uart_dbg_txbuf.
  - 4-byte shift buffer with count.
  - Generates the tx_valid strobe and consumes tx_ready.
  - Keeps the byte sequencing out of the command FSM.

Test Plan:
- Write: send 57 00 00 00 20 EF BE AD DE → one mem_valid burst with addr 32'h2000_0000, wdata 32'hDEADBEEF, wstrb 4'hF; after ready, tx bytes 06.
- Read: send 52 04 00 00 00, responder returns 32'h1234_5678 after 3 wait cycles → mem_valid held 4 cycles; tx bytes 78 56 34 12, each tx_valid only after the previous tx_ready.
- Misaligned: send 52 02 00 00 00 → mem_valid never asserted; tx byte 15.
- Bad command: send byte 41 → tx byte 15; next command 52 ... processed normally.
- Overrun and reset: an extra byte during SEND_WAIT → rx_overrun pulse, response unchanged. resetn low during BUS → mem_valid 0 asynchronously, busy 0, no tx byte.
- Timeout (UART_DBG_TIMEOUT_EN, TIMEOUT_CYCLES=16), responder never ready → mem_valid high exactly 16 cycles; tx byte 15.
